// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and timeout constants for the FIFO read-port arbiter.
// The optional handshake timeout is enabled with the FIFO_ARB_TIMEOUT_EN macro.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HS   = 2'd1,
      READ = 2'd2
   } arb_state_t;

   localparam int DEFAULT_HS_TIMEOUT = 15;
   localparam int HS_CNT_WIDTH       = 4;

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the last winner,
// wrapping modulo NUM_REQ, so the previous winner always has lowest priority.
module rr_pick #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] last,
   output logic [ID_WIDTH-1:0] winner,
   output logic                any
);

   logic [ID_WIDTH-1:0] cand [1:NUM_REQ];

   // Walk candidates from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand[k] = ID_WIDTH'((int'(last) + k) % NUM_REQ);
      end
      winner = last;
      any    = |req;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[cand[k]]) begin
            winner = cand[k];
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among NUM_REQ read_en/valid/ld consumers.
// Define FIFO_ARB_TIMEOUT_EN to abort handshakes lasting HS_TIMEOUT cycles and flag hs_err.
module fifo_rd_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int HS_TIMEOUT = DEFAULT_HS_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         read_en,
   input  logic                       empty,
   input  logic [DATA_WIDTH-1:0]      fifo_dout,
   output logic                       fifo_rd,
   output logic [NUM_REQ-1:0]         valid,
   output logic [NUM_REQ-1:0]         ld,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       hs_err
);

   localparam int ID_WIDTH = $clog2(NUM_REQ);

   arb_state_t          state;
   arb_state_t          state_next;
   logic [ID_WIDTH-1:0] pick_id;
   logic                pick_any;
   logic                grant_load;
   logic                hs_abort;
   logic [NUM_REQ-1:0]  grant_onehot;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .req    (read_en),
      .last   (grant_id),
      .winner (pick_id),
      .any    (pick_any)
   );

   assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
   assign data_out     = fifo_dout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Resetting to the top index makes requester 0 the first pick after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_id <= ID_WIDTH'(NUM_REQ - 1);
      end else if (grant_load) begin
         grant_id <= pick_id;
      end
   end

   always_comb begin
      state_next = state;
      grant_load = 1'b0;
      valid      = '0;
      ld         = '0;
      fifo_rd    = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && pick_any) begin
               grant_load = 1'b1;
               state_next = HS;
            end
         end
         HS: begin
            valid = grant_onehot;
            busy  = 1'b1;
            if (!read_en[grant_id]) begin
               state_next = READ;
            end else if (hs_abort) begin
               state_next = IDLE;
            end
         end
         READ: begin
            ld         = grant_onehot;
            fifo_rd    = 1'b1;
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef FIFO_ARB_TIMEOUT_EN
   localparam logic [HS_CNT_WIDTH-1:0] HS_LAST = HS_CNT_WIDTH'(HS_TIMEOUT - 1);

   logic [HS_CNT_WIDTH-1:0] hs_cnt;
   logic                    hs_err_q;

   // Counter idles at zero outside HS, so every HS entry starts a fresh count.
   always_ff @(posedge clk) begin
      if (rst || state != HS) begin
         hs_cnt <= '0;
      end else begin
         hs_cnt <= hs_cnt + HS_CNT_WIDTH'(1);
      end
   end

   assign hs_abort = (state == HS) && read_en[grant_id] && (hs_cnt == HS_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_err_q <= 1'b0;
      end else if (hs_abort) begin
         hs_err_q <= 1'b1;
      end
   end

   assign hs_err = hs_err_q;
`else
   assign hs_abort = 1'b0;
   assign hs_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: directed scenarios plus randomized consumers,
// compared against a transaction-level round-robin reference model.
module tb_fifo_rd_arbiter;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int HS_TO = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  read_en = '0;
   logic          empty = 1'b1;
   logic [DW-1:0] fifo_dout;
   logic          fifo_rd;
   logic [N-1:0]  valid;
   logic [N-1:0]  ld;
   logic [DW-1:0] data_out;
   logic [1:0]    grant_id;
   logic          busy;
   logic          hs_err;
   logic [12:0]   obs;

   int vectors = 0;
   int miscompares = 0;

   logic [DW-1:0] words [256];
   int head = 0;
   bit pop_at_edge = 1'b0;

   // Reference model: who owns the port, whether this cycle is the pop cycle, last winner.
   int m_owner = -1;
   bit m_read  = 1'b0;
   int m_last  = N - 1;
   bit m_err   = 1'b0;
   int m_hs    = 0;

   fifo_rd_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .HS_TIMEOUT (HS_TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .read_en   (read_en),
      .empty     (empty),
      .fifo_dout (fifo_dout),
      .fifo_rd   (fifo_rd),
      .valid     (valid),
      .ld        (ld),
      .data_out  (data_out),
      .grant_id  (grant_id),
      .busy      (busy),
      .hs_err    (hs_err)
   );

   always #5 clk = ~clk;

   assign fifo_dout = words[head[7:0]];
   assign obs = {valid, ld, fifo_rd, busy, grant_id, hs_err};

   always @(posedge clk) begin
      if (pop_at_edge) head <= head + 1;
   end

   function automatic int rr_next(input int last, input logic [N-1:0] re);
      for (int k = 1; k <= N; k++) begin
         if (re[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [12:0] exp_obs();
      logic [N-1:0] oh;
      logic [N-1:0] v_e;
      logic [N-1:0] l_e;
      logic         b_e;
      logic [1:0]   g_e;
      oh = '0;
      if (m_owner >= 0) oh[m_owner] = 1'b1;
      v_e = m_read ? '0 : oh;
      l_e = m_read ? oh : '0;
      b_e = (m_owner >= 0);
      g_e = m_last[1:0];
      return {v_e, l_e, m_read, b_e, g_e, m_err};
   endfunction

   // Apply one cycle of inputs at the falling edge and advance the model to the next cycle.
   task automatic applyStimulus(input logic r, input logic [N-1:0] re, input logic e);
      @(negedge clk);
      pop_at_edge = m_read;
      rst = r;
      read_en = re;
      empty = e;
      if (r) begin
         m_owner = -1; m_read = 1'b0; m_last = N - 1; m_err = 1'b0;
      end else if (m_read) begin
         m_read = 1'b0; m_owner = -1;
      end else if (m_owner >= 0) begin
         if (!re[m_owner]) m_read = 1'b1;
`ifdef FIFO_ARB_TIMEOUT_EN
         else if (m_hs == HS_TO - 1) begin m_owner = -1; m_err = 1'b1; end
         else m_hs++;
`endif
      end else if (!e && re != '0) begin
         m_owner = rr_next(m_last, re);
         m_last  = m_owner;
         m_hs    = 0;
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, '0, 1'b1);
      applyStimulus(1'b1, 4'b1111, 1'b0);
      settle();
      vectors++;
      if (obs !== 13'b0000_0000_0_0_11_0) begin
         miscompares++;
         $display("[TB] FAIL reset_state got=%h exp=%h", obs, 13'b0000_0000_0_0_11_0);
      end
   endtask

   task automatic test_single();
      logic [N-1:0] seq [5];
      int vcnt = 0;
      int lcnt = 0;
      seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      applyStimulus(1'b1, '0, 1'b0);
      words[head[7:0]] = 16'hA5A5;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, seq[i], 1'b0);
         settle();
         vectors++;
         if (obs !== exp_obs()) begin
            miscompares++;
            $display("[TB] FAIL single_obs cyc=%0d got=%h exp=%h", i, obs, exp_obs());
         end
         if (valid === 4'b0001) vcnt++;
         if (ld === 4'b0001 && fifo_rd === 1'b1) begin
            lcnt++;
            vectors++;
            if (data_out !== 16'hA5A5) begin
               miscompares++;
               $display("[TB] FAIL single_data got=%h exp=a5a5", data_out);
            end
         end
      end
      vectors++;
      if (vcnt != 2) begin
         miscompares++;
         $display("[TB] FAIL single_valid_cycles got=%0d exp=2", vcnt);
      end
      vectors++;
      if (lcnt != 1) begin
         miscompares++;
         $display("[TB] FAIL single_ld_pulses got=%0d exp=1", lcnt);
      end
   endtask

   task automatic test_round_robin();
      int exp_order [5];
      int order [5];
      int grants = 0;
      int rd_cnt = 0;
      logic [N-1:0] re;
      exp_order = '{0, 1, 2, 3, 0};
      order = '{-1, -1, -1, -1, -1};
      applyStimulus(1'b1, '0, 1'b0);
      settle();
      for (int c = 0; c < 40 && grants < 5; c++) begin
         re = 4'b1111 & ~valid;
         applyStimulus(1'b0, re, 1'b0);
         settle();
         vectors++;
         if (obs !== exp_obs()) begin
            miscompares++;
            $display("[TB] FAIL rr_obs cyc=%0d got=%h exp=%h", c, obs, exp_obs());
         end
         if (fifo_rd === 1'b1) rd_cnt++;
         if (ld !== '0) begin
            for (int k = 0; k < N; k++) if (ld[k] === 1'b1) order[grants] = k;
            grants++;
         end
      end
      for (int g = 0; g < 5; g++) begin
         vectors++;
         if (order[g] != exp_order[g]) begin
            miscompares++;
            $display("[TB] FAIL rr_order idx=%0d got=%0d exp=%0d", g, order[g], exp_order[g]);
         end
      end
      vectors++;
      if (rd_cnt != 5) begin
         miscompares++;
         $display("[TB] FAIL rr_pop_count got=%0d exp=5", rd_cnt);
      end
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
   endtask

   task automatic test_empty_hold();
      applyStimulus(1'b1, '0, 1'b1);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 4'b0110, 1'b1);
         settle();
         vectors++;
         if ({valid, ld, fifo_rd, busy} !== 10'b0) begin
            miscompares++;
            $display("[TB] FAIL empty_quiet cyc=%0d got=%h exp=0", c, {valid, ld, fifo_rd, busy});
         end
      end
      applyStimulus(1'b0, 4'b0110, 1'b0);
      settle();
      vectors++;
      if (grant_id !== 2'd1 || valid !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL empty_release got=%0d/%b exp=1/0010", grant_id, valid);
      end
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, '0, 1'b0);
         settle();
         vectors++;
         if (obs !== exp_obs()) begin
            miscompares++;
            $display("[TB] FAIL empty_finish cyc=%0d got=%h exp=%h", c, obs, exp_obs());
         end
      end
   endtask

   task automatic test_reset_mid_hs();
      applyStimulus(1'b1, '0, 1'b0);
      applyStimulus(1'b0, 4'b0100, 1'b0);
      settle();
      vectors++;
      if (valid !== 4'b0100) begin
         miscompares++;
         $display("[TB] FAIL midrst_hs got=%b exp=0100", valid);
      end
      applyStimulus(1'b1, 4'b0100, 1'b0);
      settle();
      vectors++;
      if ({valid, ld, fifo_rd, busy, grant_id} !== {4'b0, 4'b0, 1'b0, 1'b0, 2'd3}) begin
         miscompares++;
         $display("[TB] FAIL midrst_idle got=%h exp=%h", {valid, ld, fifo_rd, busy, grant_id},
                  {4'b0, 4'b0, 1'b0, 1'b0, 2'd3});
      end
      applyStimulus(1'b0, '0, 1'b0);
      settle();
      vectors++;
      if (fifo_rd !== 1'b0 || ld !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrst_nopop got=%b/%b exp=0/0000", fifo_rd, ld);
      end
   endtask

   task automatic test_hold_priority();
      logic [N-1:0] seq [12];
      logic [N-1:0] exp_v [12];
      seq   = '{4'b0100, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                4'b0001, 4'b0001, 4'b0001, 4'b0000};
      exp_v = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                4'b0000, 4'b0000, 4'b0001, 4'b0000};
      applyStimulus(1'b1, '0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         applyStimulus(1'b0, seq[c], 1'b0);
         settle();
         vectors++;
         if (valid !== exp_v[c] || obs !== exp_obs()) begin
            miscompares++;
            $display("[TB] FAIL hold_prio cyc=%0d got=%h exp_valid=%b exp=%h", c, obs, exp_v[c], exp_obs());
         end
      end
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
   endtask

   task automatic test_timeout();
      int vcnt = 0;
      int rd_cnt = 0;
`ifdef FIFO_ARB_TIMEOUT_EN
      int exp_vcnt = 15;
      logic exp_err = 1'b1;
      logic [1:0] exp_gid = 2'd3;
`else
      int exp_vcnt = 20;
      logic exp_err = 1'b0;
      logic [1:0] exp_gid = 2'd1;
`endif
      applyStimulus(1'b1, '0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b0, 4'b1010, 1'b0);
         settle();
         vectors++;
         if (obs !== exp_obs()) begin
            miscompares++;
            $display("[TB] FAIL timeout_obs cyc=%0d got=%h exp=%h", c, obs, exp_obs());
         end
         if (valid === 4'b0010) vcnt++;
         if (fifo_rd === 1'b1) rd_cnt++;
      end
      vectors++;
      if (vcnt != exp_vcnt || rd_cnt != 0) begin
         miscompares++;
         $display("[TB] FAIL timeout_len got=%0d/%0d exp=%0d/0", vcnt, rd_cnt, exp_vcnt);
      end
      vectors++;
      if (hs_err !== exp_err || grant_id !== exp_gid) begin
         miscompares++;
         $display("[TB] FAIL timeout_flag got=%b/%0d exp=%b/%0d", hs_err, grant_id, exp_err, exp_gid);
      end
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, 1'b0);
      settle();
      vectors++;
      if (hs_err !== exp_err) begin
         miscompares++;
         $display("[TB] FAIL timeout_sticky got=%b exp=%b", hs_err, exp_err);
      end
      applyStimulus(1'b1, '0, 1'b0);
      settle();
      vectors++;
      if (hs_err !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout_clear got=%b exp=0", hs_err);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] re = '0;
      int hold [N];
      logic r;
      logic e;
      hold = '{0, 0, 0, 0};
      applyStimulus(1'b1, '0, 1'b0);
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (valid[i] === 1'b1) begin
               if (hold[i] == 0) re[i] = 1'b0;
               else hold[i]--;
            end else if (!re[i]) begin
               if ($urandom_range(2) == 0) begin
                  re[i] = 1'b1;
                  hold[i] = ($urandom_range(7) == 0) ? 20 : int'($urandom_range(3));
               end
            end else if ($urandom_range(15) == 0) begin
               re[i] = 1'b0;
            end
         end
         e = ($urandom_range(3) == 0);
         r = ($urandom_range(63) == 0);
         applyStimulus(r, re, e);
         settle();
         vectors++;
         if (obs !== exp_obs()) begin
            miscompares++;
            $display("[TB] FAIL random_obs cyc=%0d got=%h exp=%h", c, obs, exp_obs());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) words[i] = DW'($urandom);
      test_reset();
      test_single();
      test_round_robin();
      test_empty_hold();
      test_reset_mid_hs();
      test_hold_priority();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
